// File: rtl/timer_core.sv
// Stopwatch / countdown engine: one registered FSM, a binary hh:mm:ss counter
// and a lap snapshot, presented as four BCD digits (15 = dash).
module timer_core #(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       mode,
  input  logic       set,
  input  logic       show,
  input  logic       btn1,
  input  logic       btn2,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3,
  output logic [2:0] state,
  output logic       running,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    SW_RUN   = 3'b001,
    SW_LAP   = 3'b010,
    SW_STOP  = 3'b011,
    CD_SET   = 3'b100,
    CD_RUN   = 3'b101,
    CD_LAP   = 3'b110,
    CD_PAUSE = 3'b111
  } state_t;

  localparam logic [6:0] HMAX = 7'(HOUR_MAX);

  state_t     state_q, state_d;
  logic [6:0] hh_q, hh_d, lap_hh_q, lap_hh_d;
  logic [5:0] mm_q, mm_d, lap_mm_q, lap_mm_d;
  logic [5:0] ss_q, ss_d, lap_ss_q, lap_ss_d;
  logic       done_q, done_d;
  logic       mode_q;
  logic       running_q;
  logic       running_d;
  logic       btn2_only;
  logic       is_zero;
  logic       is_one;
  logic       sw_count;
  logic       cd_count;

  always_comb begin
    state_d  = state_q;
    hh_d     = hh_q;
    mm_d     = mm_q;
    ss_d     = ss_q;
    lap_hh_d = lap_hh_q;
    lap_mm_d = lap_mm_q;
    lap_ss_d = lap_ss_q;
    done_d   = done_q;
    btn2_only = btn2 & ~btn1;
    is_zero  = (hh_q == 7'd0) && (mm_q == 6'd0) && (ss_q == 6'd0);
    is_one   = (hh_q == 7'd0) && (mm_q == 6'd0) && (ss_q == 6'd1);
    sw_count = ~mode_q & tick & ((state_q == SW_RUN) || (state_q == SW_LAP));
    cd_count = mode_q & tick & ((state_q == CD_RUN) || (state_q == CD_LAP)) & ~is_zero;

    if (mode != mode_q) begin
      state_d  = IDLE;
      hh_d     = 7'd0;
      mm_d     = 6'd0;
      ss_d     = 6'd0;
      lap_hh_d = 7'd0;
      lap_mm_d = 6'd0;
      lap_ss_d = 6'd0;
      done_d   = 1'b0;
    end else begin
      // Counting is decided by the pre-edge state, before any button moves it.
      if (sw_count) begin
        if (ss_q == 6'd59) begin
          ss_d = 6'd0;
          mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
        end else begin
          ss_d = ss_q + 6'd1;
        end
      end
      if (cd_count) begin
        if (ss_q != 6'd0) begin
          ss_d = ss_q - 6'd1;
        end else begin
          ss_d = 6'd59;
          if (mm_q != 6'd0) begin
            mm_d = mm_q - 6'd1;
          end else begin
            mm_d = 6'd59;
            hh_d = hh_q - 7'd1;
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (mode_q) begin
            if (set) begin
              state_d = CD_SET;
              done_d  = 1'b0;
            end
          end else if (btn1) begin
            state_d = SW_RUN;
          end
        end
        SW_RUN: begin
          if (btn1) begin
            state_d = SW_STOP;
          end else if (btn2_only) begin
            state_d  = SW_LAP;
            lap_hh_d = hh_q;
            lap_mm_d = mm_q;
            lap_ss_d = ss_q;
          end
        end
        SW_LAP: begin
          if (btn1)           state_d = SW_STOP;
          else if (btn2_only) state_d = SW_RUN;
        end
        SW_STOP: begin
          if (btn1) begin
            state_d = SW_RUN;
          end else if (btn2_only) begin
            state_d  = IDLE;
            hh_d     = 7'd0;
            mm_d     = 6'd0;
            ss_d     = 6'd0;
            lap_hh_d = 7'd0;
            lap_mm_d = 6'd0;
            lap_ss_d = 6'd0;
          end
        end
        CD_SET: begin
          ss_d = 6'd0;
          if (btn1)      hh_d = (hh_q == HMAX) ? 7'd0 : hh_q + 7'd1;
          if (btn2_only) mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
          if (!set)      state_d = CD_PAUSE;
        end
        CD_PAUSE: begin
          if (set) begin
            state_d = CD_SET;
            done_d  = 1'b0;
          end else if (btn1) begin
            done_d = 1'b0;
            if (!is_zero) state_d = CD_RUN;
          end
        end
        CD_RUN: begin
          if (btn1) begin
            state_d = CD_PAUSE;
          end else if (btn2_only) begin
            state_d  = CD_LAP;
            lap_hh_d = hh_q;
            lap_mm_d = mm_q;
            lap_ss_d = ss_q;
          end
        end
        CD_LAP: begin
          if (btn1)           state_d = CD_PAUSE;
          else if (btn2_only) state_d = CD_RUN;
        end
      endcase

      // Reaching zero overrides whatever the buttons asked for.
      if (cd_count && is_one) begin
        done_d  = 1'b1;
        state_d = CD_PAUSE;
      end
    end

    running_d = (state_d == SW_RUN) || (state_d == SW_LAP) ||
                (state_d == CD_RUN) || (state_d == CD_LAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hh_q      <= 7'd0;
      mm_q      <= 6'd0;
      ss_q      <= 6'd0;
      lap_hh_q  <= 7'd0;
      lap_mm_q  <= 6'd0;
      lap_ss_q  <= 6'd0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      lap_hh_q  <= lap_hh_d;
      lap_mm_q  <= lap_mm_d;
      lap_ss_q  <= lap_ss_d;
      done_q    <= done_d;
      mode_q    <= mode;
      running_q <= running_d;
    end
  end

  function automatic logic [3:0] tens(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] ones(input logic [6:0] v);
    logic [6:0] r;
    r = v % 7'd10;
    return r[3:0];
  endfunction

  logic       show_lap;
  logic [6:0] src_hh, src_mm, src_ss;

  always_comb begin
    show_lap = (state_q == SW_LAP) || (state_q == CD_LAP);
    src_hh   = show_lap ? lap_hh_q : hh_q;
    src_mm   = {1'b0, show_lap ? lap_mm_q : mm_q};
    src_ss   = {1'b0, show_lap ? lap_ss_q : ss_q};
    if (!mode_q) begin
      disp0 = tens(src_mm);
      disp1 = ones(src_mm);
      disp2 = tens(src_ss);
      disp3 = ones(src_ss);
    end else if (!show) begin
      disp0 = tens(src_hh);
      disp1 = ones(src_hh);
      disp2 = tens(src_mm);
      disp3 = ones(src_mm);
    end else begin
      disp0 = 4'd15;
      disp1 = 4'd15;
      disp2 = tens(src_ss);
      disp3 = ones(src_ss);
    end
  end

  assign state   = state_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: directed steps plus random bursts, checked against a
// total-seconds reference model.
module tb_timer_core;

  localparam int HMAX = 23;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       mode = 1'b0;
  logic       set = 1'b0;
  logic       show = 1'b0;
  logic       btn1 = 1'b0;
  logic       btn2 = 1'b0;
  logic [3:0] disp0, disp1, disp2, disp3;
  logic [2:0] state;
  logic       running, done;

  int errors = 0;
  int checks = 0;

  // Reference model: time held as a single seconds count.
  int m_state = 0;
  int m_secs  = 0;
  int m_lap   = 0;
  bit m_done  = 1'b0;
  bit m_modeq = 1'b0;

  timer_core #(.HOUR_MAX(HMAX)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .set(set), .show(show),
    .btn1(btn1), .btn2(btn2), .disp0(disp0), .disp1(disp1), .disp2(disp2),
    .disp3(disp3), .state(state), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, ".d0"}, disp0, a);
    chk({tag, ".d1"}, disp1, b);
    chk({tag, ".d2"}, disp2, c);
    chk({tag, ".d3"}, disp3, d);
  endtask

  task automatic compare_all(input string tag);
    int src, h, m, s;
    int e[4];
    src = (m_state == 2 || m_state == 6) ? m_lap : m_secs;
    h = src / 3600;
    m = (src / 60) % 60;
    s = src % 60;
    if (!m_modeq)  e = '{m / 10, m % 10, s / 10, s % 10};
    else if (!show) e = '{h / 10, h % 10, m / 10, m % 10};
    else            e = '{15, 15, s / 10, s % 10};
    chk({tag, ".state"}, state, m_state);
    chk({tag, ".running"}, running, (m_state == 1 || m_state == 2 || m_state == 5 || m_state == 6));
    chk({tag, ".done"}, done, m_done);
    chk_disp(tag, e[0], e[1], e[2], e[3]);
  endtask

  task automatic model_update();
    int ns, nsecs, h, m;
    bit b2e, force_pause;
    if (mode != m_modeq) begin
      m_state = 0; m_secs = 0; m_lap = 0; m_done = 1'b0; m_modeq = mode;
      return;
    end
    b2e = btn2 && !btn1;
    ns = m_state;
    nsecs = m_secs;
    force_pause = 1'b0;
    if (!m_modeq) begin
      if (tick && (m_state == 1 || m_state == 2)) nsecs = (m_secs + 1) % 3600;
      case (m_state)
        0: if (btn1) ns = 1;
        1: if (btn1) ns = 3; else if (b2e) begin ns = 2; m_lap = m_secs; end
        2: if (btn1) ns = 3; else if (b2e) ns = 1;
        3: if (btn1) ns = 1; else if (b2e) begin ns = 0; nsecs = 0; m_lap = 0; end
        default: ns = 0;
      endcase
    end else begin
      if (tick && (m_state == 5 || m_state == 6) && m_secs > 0) begin
        nsecs = m_secs - 1;
        if (m_secs == 1) begin m_done = 1'b1; force_pause = 1'b1; end
      end
      case (m_state)
        0: if (set) begin ns = 4; m_done = 1'b0; end
        4: begin
          h = m_secs / 3600;
          m = (m_secs / 60) % 60;
          if (btn1) h = (h == HMAX) ? 0 : h + 1;
          if (b2e)  m = (m + 1) % 60;
          nsecs = h * 3600 + m * 60;
          if (!set) ns = 7;
        end
        5: if (btn1) ns = 7; else if (b2e) begin ns = 6; m_lap = m_secs; end
        6: if (btn1) ns = 7; else if (b2e) ns = 5;
        7: if (set) begin ns = 4; m_done = 1'b0; end
           else if (btn1) begin m_done = 1'b0; if (m_secs != 0) ns = 5; end
        default: ns = 0;
      endcase
    end
    m_state = force_pause ? 7 : ns;
    m_secs  = nsecs;
  endtask

  task automatic step(input string tag, input bit t, input bit b1i, input bit b2i);
    @(negedge clk);
    tick = t; btn1 = b1i; btn2 = b2i;
    model_update();
    @(posedge clk);
    #1;
    tick = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
    compare_all(tag);
    if (b1i || b2i)
      $display("%s: tick=%0b btn1=%0b btn2=%0b -> state=%0d disp=%0d%0d:%0d%0d done=%0b",
               tag, t, b1i, b2i, state, disp0, disp1, disp2, disp3, done);
  endtask

  task automatic set_show(input bit v);
    show = v;
    #1;
    compare_all("show");
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_state = 0; m_secs = 0; m_lap = 0; m_done = 1'b0; m_modeq = 1'b0;
    chk({tag, ".state"}, state, 0);
    chk({tag, ".running"}, running, 0);
    chk_disp(tag, 0, 0, 0, 0);
    compare_all(tag);
    $display("%s: async reset asserted, state=%0d", tag, state);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hp, mp;
    // Power-on reset
    #3;
    chk("por.state", state, 0);
    chk_disp("por", 0, 0, 0, 0);
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Stopwatch: count, lap freeze, lap release
    step("sw_start", 0, 1, 0);
    repeat (75) step("sw_tick", 1, 0, 0);
    chk_disp("sw_75", 0, 1, 1, 5);
    step("sw_lap", 0, 0, 1);
    repeat (5) step("sw_lap_tick", 1, 0, 0);
    chk_disp("sw_lap_frozen", 0, 1, 1, 5);
    chk("sw_live", m_secs, 80);
    step("sw_unlap", 0, 0, 1);
    chk_disp("sw_unlap", 0, 1, 2, 0);
    step("sw_stop", 0, 1, 0);
    step("sw_clear", 0, 0, 1);
    chk_disp("sw_clear", 0, 0, 0, 0);

    // Reset mid-run at 12:34
    step("sw_start2", 0, 1, 0);
    repeat (754) step("sw_tick", 1, 0, 0);
    chk_disp("sw_1234", 1, 2, 3, 4);
    async_reset("rst_mid");

    // Wrap at 59:59 and same-cycle corner cases
    step("sw_start3", 0, 1, 0);
    repeat (3598) step("sw_tick", 1, 0, 0);
    chk_disp("sw_5958", 5, 9, 5, 8);
    repeat (2) step("sw_tick", 1, 0, 0);
    chk_disp("sw_wrap", 0, 0, 0, 0);
    step("sw_both", 0, 1, 1);
    chk("sw_both.state", state, 3);
    step("sw_resume", 1, 1, 0);
    step("sw_tick_stop", 1, 1, 0);
    chk_disp("sw_tick_stop", 0, 0, 0, 1);
    chk("sw_tick_stop.state", state, 3);
    step("sw_resume2", 0, 1, 0);
    step("sw_tick_lap", 1, 0, 1);
    chk_disp("sw_tick_lap", 0, 0, 0, 1);

    repeat (300) step("sw_rand", 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));

    // Countdown setting with hour/minute wrap
    mode = 1'b1;
    step("cd_mode", 0, 0, 0);
    chk("cd_mode.state", state, 0);
    set = 1'b1;
    step("cd_set", 0, 0, 0);
    repeat (25) step("cd_hh", 0, 1, 0);
    repeat (61) step("cd_mm", 0, 0, 1);
    set = 1'b0;
    step("cd_pause", 0, 0, 0);
    chk_disp("cd_0101", 0, 1, 0, 1);
    chk("cd_pause.state", state, 7);

    // Countdown to zero from 00:01:00
    set = 1'b1;
    step("cd_set2", 0, 0, 0);
    repeat (23) step("cd_hh", 0, 1, 0);
    set = 1'b0;
    step("cd_pause2", 0, 0, 0);
    step("cd_run", 0, 1, 0);
    repeat (58) step("cd_tick", 1, 0, 0);
    set_show(1'b1);
    chk_disp("cd_0002", 15, 15, 0, 2);
    repeat (2) step("cd_tick", 1, 0, 0);
    chk("cd_zero.done", done, 1);
    chk("cd_zero.state", state, 7);
    chk("cd_zero.running", running, 0);
    chk_disp("cd_zero", 15, 15, 0, 0);
    step("cd_extra_tick", 1, 0, 0);
    step("cd_btn1_zero", 0, 1, 0);
    chk("cd_btn1_zero.state", state, 7);

    // Random countdown activity from 00:06:00
    set = 1'b1;
    step("cd_set3", 0, 0, 0);
    repeat (6) step("cd_mm", 0, 0, 1);
    set = 1'b0;
    step("cd_pause3", 0, 0, 0);
    repeat (400) step("cd_rand", 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));

    // 01:00:00 -> 00:59:59 borrow, then mode change mid-run
    set_show(1'b0);
    if (m_state == 5 || m_state == 6) step("cd_halt", 0, 1, 0);
    set = 1'b1;
    step("cd_set4", 0, 0, 0);
    hp = (1 - m_secs / 3600 + HMAX + 1) % (HMAX + 1);
    mp = (60 - (m_secs / 60) % 60) % 60;
    repeat (hp) step("cd_hh", 0, 1, 0);
    repeat (mp) step("cd_mm", 0, 0, 1);
    set = 1'b0;
    step("cd_pause4", 0, 0, 0);
    chk_disp("cd_0100", 0, 1, 0, 0);
    step("cd_run4", 0, 1, 0);
    step("cd_borrow", 1, 0, 0);
    chk_disp("cd_borrow_hm", 0, 0, 5, 9);
    set_show(1'b1);
    chk_disp("cd_borrow_ss", 15, 15, 5, 9);
    set_show(1'b0);
    mode = 1'b0;
    step("mode_flip", 1, 1, 0);
    chk("mode_flip.state", state, 0);
    chk("mode_flip.done", done, 0);
    chk("mode_flip.running", running, 0);
    chk_disp("mode_flip", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_core.md
Name: timer_core

Overview:
- Single-clock stopwatch / countdown engine for the clock-display board.
- Consumes one-cycle button pulses (after debounce and one-pulse) and a 1 Hz tick enable. Produces four BCD display digits for the LCD RAM controller's in0..in3 inputs.
- Replaces the ripple digit counters and the combinational lap latch with one registered FSM, a registered hh:mm:ss counter and a registered lap snapshot.

Parameters:
HOUR_MAX, 23, highest hour value reachable while setting the countdown (wraps to 0 after it)

Ports:
clk  input  1  system clock; every register is on its rising edge
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-clk-cycle enable, 1 Hz rate, already in clk domain
mode  input  1  0 = stopwatch, 1 = countdown
set  input  1  level; countdown setting request
show  input  1  countdown display select: 0 = hh:mm, 1 = --:ss
btn1  input  1  one-cycle pulse: start/stop, or hour+1 while setting
btn2  input  1  one-cycle pulse: lap/clear, or minute+1 while setting
disp0  output  4  leftmost BCD digit (15 = blank/dash code)
disp1  output  4  second digit
disp2  output  4  third digit
disp3  output  4  rightmost digit
state  output  3  current FSM state encoding
running  output  1  1 in SW_RUN, SW_LAP, CD_RUN, CD_LAP
done  output  1  countdown reached zero; sticky

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hh, mm, ss, lap, done and mode_q all 0.
  - disp0..3 = 0, running = 0.
- States: IDLE=000, SW_RUN=001, SW_LAP=010, SW_STOP=011, CD_SET=100, CD_RUN=101, CD_LAP=110, CD_PAUSE=111.
- Mode change: on any cycle where mode != mode_q:
  - next state = IDLE; hh, mm, ss, lap and done cleared.
  - buttons and tick ignored that cycle.
  - mode_q <= mode.
- Button priority: btn1 and btn2 in the same cycle means btn1 is acted on and btn2 is dropped.
- Stopwatch (mode=0):
  - IDLE: btn1 -> SW_RUN.
  - SW_RUN: btn1 -> SW_STOP; btn2 -> SW_LAP and lap <= current mm:ss.
  - SW_LAP: btn2 -> SW_RUN; btn1 -> SW_STOP.
  - SW_STOP: btn1 -> SW_RUN; btn2 -> IDLE, clearing counters.
  - Counting: tick in SW_RUN or SW_LAP increments ss. ss 59->00 carries to mm; mm:ss 59:59 -> 00:00. hh stays 0.
- Countdown (mode=1):
  - IDLE or CD_PAUSE with set=1 -> CD_SET; done cleared.
  - CD_SET: ss forced to 00.
    - btn1: hh+1, wrapping HOUR_MAX->0.
    - btn2: mm+1, wrapping 59->0, with no carry into hh.
    - set=0 -> CD_PAUSE.
  - CD_PAUSE: btn1 -> CD_RUN only if hh:mm:ss != 0 (otherwise stay); done cleared on btn1.
  - CD_RUN: btn1 -> CD_PAUSE; btn2 -> CD_LAP and lap <= current hh:mm:ss.
  - CD_LAP: btn2 -> CD_RUN; btn1 -> CD_PAUSE.
  - Counting: tick in CD_RUN or CD_LAP decrements.
    - ss 00 -> 59 with a borrow from mm; mm 00 -> 59 with a borrow from hh.
    - Decrement from 00:00:01 -> 00:00:00, and the same edge sets done=1 and state=CD_PAUSE, from either CD_RUN or CD_LAP.
    - Never decrements below zero.
- Simultaneous events: the counter update is decided by the pre-edge state.
  - tick together with a stop btn1 still counts that edge.
  - Lap capture on the same cycle as tick stores the pre-tick value.
- Display: combinational from registers, so it updates in the cycle after the causing edge.
  - mode=0: disp = mm1, mm0, ss1, ss0. Source is lap in SW_LAP, live otherwise.
  - mode=1, show=0: disp = hh1, hh0, mm1, mm0.
  - mode=1, show=1: disp = 15, 15, ss1, ss0.
  - In countdown, the source is lap in CD_LAP, live otherwise.
- All digits are BCD 0-9 except the dash code 15. No illegal BCD value ever appears.

Test Plan:
- Reset mid-run at 12:34 in SW_RUN, pulse rst_n -> same-cycle state=000, disp=0,0,0,0, running=0.
- mode=0: btn1, 75 ticks -> disp=0,1,1,5. btn2, then 5 ticks -> disp stays 0,1,1,5 while live=01:20. btn2 -> disp=0,1,2,0.
- Stopwatch wrap: preload to 59:58 via ticks, 2 ticks -> disp=0,0,0,0. btn1+btn2 same cycle -> SW_STOP, lap not captured.
- mode=1: set=1, btn1 x25 with HOUR_MAX=23 -> hh=01. btn2 x61 -> mm=01. set=0 -> CD_PAUSE, disp=0,1,0,1.
- Countdown from 00:00:02: btn1, 2 ticks -> ss=00, done=1, state=111, running=0. A further tick changes nothing. btn1 at zero stays in 111.
- Countdown at 01:00:00 in CD_RUN, tick -> 00:59:59, show=1 gives disp=15,15,5,9. Toggle mode mid-run -> IDLE, all cleared, done=0.
